csr_ctrl: RTL and testbench

Machine-mode CSR controller for the AdamRiscv core. Sits between the execute stage and the CSR storage flops: it accepts one CSR instruction at a time over a valid/ready handshake and performs CSRRW/CSRRS/CSRRC read-modify-write. It also runs the 64-bit cycle and instret counters, and sequences trap entry and `mret` updates of `mstatus`/`mepc`/`mcause`.

---
 rtl/csr_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_csr_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: serialized CSRRW/RS/RC access, 64-bit cycle and
// instret counters, and trap entry / mret sequencing of mstatus, mepc, mcause.
module csr_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic        req_wsup,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_valid,
    output logic        evt_ready,
    input  logic        instret_pulse,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_o,
    output logic        irq_en,
    output logic [1:0]  dbg_state
);
    // Request handshake: a request transfers on a rising edge where
    // req_valid & req_ready; rsp_valid is a single-cycle strobe, no back-pressure.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic        wsup_q, wsup_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [31:0] old_val, new_val, mstatus_val;
    logic        mapped, write_en, read_only, illegal;

    assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        case (addr_q)
            12'h300: old_val = mstatus_val;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'hB00, 12'hC00: old_val = mcycle_q[31:0];
            12'hB80, 12'hC80: old_val = mcycle_q[63:32];
            12'hB02, 12'hC02: old_val = minstret_q[31:0];
            12'hB82, 12'hC82: old_val = minstret_q[63:32];
            12'hF14: old_val = HART_ID;
            default: mapped = 1'b0;
        endcase
    end

    // RW always writes; RS/RC become pure reads when the source was x0/zimm=0.
    assign write_en  = (op_q == OP_RW) || !wsup_q;
    assign read_only = (addr_q[11:10] == 2'b11);
    assign illegal   = (op_q == 2'b00) || !mapped || (read_only && write_en);

    always_comb begin
        case (op_q)
            OP_RS:   new_val = old_val | wdata_q;
            OP_RC:   new_val = old_val & ~wdata_q;
            default: new_val = wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        wsup_d     = wsup_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        illegal_d  = illegal_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret_pulse};
        case (state_q)
            S_IDLE: begin
                if (trap_valid) begin
                    mepc_d   = trap_pc & ~32'h3;
                    mcause_d = trap_cause;
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                end else if (mret_valid) begin
                    mie_d  = mpie_q;
                    mpie_d = 1'b1;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    op_d    = req_op;
                    wsup_d  = req_wsup;
                    wdata_d = req_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d   = S_RESP;
                rdata_d   = illegal ? 32'd0 : old_val;
                illegal_d = illegal;
                if (!illegal && write_en) begin
                    // Counter half-writes override this cycle's increment, no carry.
                    case (addr_q)
                        12'h300: begin
                            mie_d  = new_val[3];
                            mpie_d = new_val[7];
                        end
                        12'h305: mtvec_d    = new_val & ~32'h3;
                        12'h340: mscratch_d = new_val;
                        12'h341: mepc_d     = new_val & ~32'h3;
                        12'h342: mcause_d   = new_val;
                        12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                        12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                        12'hB02: minstret_d = {minstret_q[63:32], new_val};
                        12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                        default: ;
                    endcase
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            op_q       <= '0;
            wsup_q     <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            illegal_q  <= 1'b0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            wsup_q     <= wsup_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            illegal_q  <= illegal_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !trap_valid && !mret_valid;
    assign evt_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_illegal = illegal_q;
    assign trap_vector = {mtvec_q[31:2], 2'b00};
    assign mepc_o      = mepc_q;
    assign irq_en      = mie_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl: CSR read-modify-write, illegal accesses,
// trap/mret sequencing, counters and reset abort of an in-flight request.
module tb_csr_ctrl;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_wsup;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata, rsp_rdata, trap_pc, trap_cause, trap_vector, mepc_o;
    logic        rsp_valid, rsp_illegal, trap_valid, mret_valid, evt_ready;
    logic        instret_pulse, irq_en;
    logic [1:0]  dbg_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] rd;
    logic        ill;

    csr_ctrl #(.MTVEC_RESET(32'h0000_1003), .HART_ID(32'h0000_0005)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_wsup(req_wsup), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .evt_ready(evt_ready), .instret_pulse(instret_pulse),
        .trap_vector(trap_vector), .mepc_o(mepc_o), .irq_en(irq_en),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request; checks response timing and returns rdata/illegal.
    task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic wsup,
                          input logic [31:0] wd, output logic [31:0] r, output logic il);
        int waits = 0;
        @(negedge clk);
        req_addr = a; req_op = op; req_wsup = wsup; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rsp_not_early", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        r  = rsp_rdata;
        il = rsp_illegal;
        @(posedge clk); #1;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0; req_wsup = 1'b0;
        req_wdata = '0; trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
        mret_valid = 1'b0; instret_pulse = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_evt_ready", {31'd0, evt_ready}, 32'd1);
        chk("rst_irq_en", {31'd0, irq_en}, 32'd0);
        chk("rst_trap_vector", trap_vector, 32'h0000_1000);
        chk("rst_mepc", mepc_o, 32'd0);

        do_req(12'h300, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("mstatus_reset", rd, 32'h0000_1800);
        chk("mstatus_legal", {31'd0, ill}, 32'd0);

        do_req(12'h340, 2'b01, 1'b0, 32'hDEAD_BEEF, rd, ill);
        chk("scratch_rw", rd, 32'h0);
        do_req(12'h340, 2'b10, 1'b0, 32'h0000_0010, rd, ill);
        chk("scratch_rs", rd, 32'hDEAD_BEEF);
        do_req(12'h340, 2'b11, 1'b0, 32'hFFFF_0000, rd, ill);
        chk("scratch_rc", rd, 32'hDEAD_BEFF);
        do_req(12'h340, 2'b10, 1'b1, 32'hFFFF_FFFF, rd, ill);
        chk("scratch_final", rd, 32'h0000_BEFF);

        do_req(12'h300, 2'b10, 1'b0, 32'h0000_0008, rd, ill);
        chk("mie_set_old", rd, 32'h0000_1800);
        chk("mie_set_irq", {31'd0, irq_en}, 32'd1);

        // Trap collides with a request: the trap must win.
        @(negedge clk);
        trap_valid = 1'b1; trap_pc = 32'h0000_1234; trap_cause = 32'h0000_000B;
        req_valid = 1'b1; req_addr = 12'h340; req_op = 2'b01; req_wsup = 1'b0;
        req_wdata = 32'h0000_0055;
        #1;
        chk("trap_req_ready", {31'd0, req_ready}, 32'd0);
        chk("trap_evt_ready", {31'd0, evt_ready}, 32'd1);
        @(posedge clk); #1;
        trap_valid = 1'b0; req_valid = 1'b0;
        chk("trap_mepc", mepc_o, 32'h0000_1234);
        chk("trap_irq_en", {31'd0, irq_en}, 32'd0);
        chk("trap_state_idle", {30'd0, dbg_state}, 32'd0);
        do_req(12'h340, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("trap_no_req_write", rd, 32'h0000_BEFF);
        do_req(12'h300, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("trap_mstatus", rd, 32'h0000_1880);
        do_req(12'h342, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("trap_mcause", rd, 32'h0000_000B);

        @(negedge clk); mret_valid = 1'b1;
        @(posedge clk); #1; mret_valid = 1'b0;
        chk("mret_irq_en", {31'd0, irq_en}, 32'd1);
        do_req(12'h300, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("mret_mstatus", rd, 32'h0000_1888);

        do_req(12'hC00, 2'b01, 1'b0, 32'h1234_5678, rd, ill);
        chk("ro_write_illegal", {31'd0, ill}, 32'd1);
        chk("ro_write_rdata", rd, 32'd0);
        do_req(12'hC00, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("ro_read_legal", {31'd0, ill}, 32'd0);
        do_req(12'hF14, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("hartid", rd, 32'h0000_0005);
        do_req(12'h7C0, 2'b01, 1'b0, 32'h1, rd, ill);
        chk("unmapped_illegal", {31'd0, ill}, 32'd1);
        do_req(12'h340, 2'b00, 1'b0, 32'h1, rd, ill);
        chk("op00_illegal", {31'd0, ill}, 32'd1);
        chk("op00_rdata", rd, 32'd0);
        do_req(12'h340, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("illegal_no_change", rd, 32'h0000_BEFF);

        // Write lands at N+1, read samples in ACCESS after N+3: two increments.
        do_req(12'hB00, 2'b01, 1'b0, 32'h0000_0100, rd, ill);
        do_req(12'hB00, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("mcycle_count", rd, 32'h0000_0102);
        do_req(12'hB80, 2'b01, 1'b0, 32'h0000_0005, rd, ill);
        do_req(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFE, rd, ill);
        do_req(12'hB80, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("mcycleh_wrap", rd, 32'h0000_0006);
        do_req(12'hC80, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("cycleh_alias", rd, 32'h0000_0006);

        @(negedge clk); instret_pulse = 1'b1;
        repeat (3) @(negedge clk);
        instret_pulse = 1'b0;
        do_req(12'hB02, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("minstret", rd, 32'd3);
        do_req(12'hC02, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("instret_alias", rd, 32'd3);

        do_req(12'h341, 2'b01, 1'b0, 32'h0000_2223, rd, ill);
        chk("mepc_old", rd, 32'h0000_1234);
        chk("mepc_aligned", mepc_o, 32'h0000_2220);

        // Reset held over the ACCESS edge aborts the request.
        @(negedge clk);
        req_addr = 12'h305; req_op = 2'b01; req_wsup = 1'b0; req_wdata = 32'h0000_0100;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst_n = 1'b0;
        chk("abort_state_access", {30'd0, dbg_state}, 32'd1);
        @(posedge clk); #1;
        chk("abort_no_rsp1", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("abort_no_rsp2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("abort_trap_vector", trap_vector, 32'h0000_1000);
        chk("abort_irq_en", {31'd0, irq_en}, 32'd0);
        do_req(12'h305, 2'b10, 1'b1, 32'h0, rd, ill);
        chk("abort_mtvec", rd, 32'h0000_1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
